macro_io_arbiter: RTL and testbench

MACRO_IO_ARBITER -- requirements
Module: macro_io_arbiter

---
 rtl/macro_io_arbiter.sv | 160 ++++++++++++++++
 tb/tb_macro_io_arbiter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/macro_io_arbiter.sv
// Round-robin arbiter that time-shares the north pad bus between several macros.
// Each grant has a bounded tenure and is followed by a fixed bus-idle turnaround.
module macro_io_arbiter #(
  parameter int NUM_MACROS = 4,
  parameter int WIDTH      = 10,
  parameter int MAX_TENURE = 16,
  parameter int TURNAROUND = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_MACROS-1:0]         req,
  input  logic [NUM_MACROS-1:0]         rel,
  input  logic [NUM_MACROS*WIDTH-1:0]   mac_o,
  input  logic [NUM_MACROS*WIDTH-1:0]   mac_oe,
  input  logic [WIDTH-1:0]              pad_i,
  output logic [WIDTH-1:0]              mac_i,
  output logic [WIDTH-1:0]              pad_o,
  output logic [WIDTH-1:0]              pad_oe,
  output logic [NUM_MACROS-1:0]         gnt,
  output logic [$clog2(NUM_MACROS)-1:0] owner,
  output logic                          busy,
  output logic                          expired
);

  // state | meaning
  // IDLE  | bus free, arbitrating among pending requests
  // GRANT | one macro drives the pads, tenure counting
  // TURN  | bus held idle between owners
  typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_TURN} state_t;

  localparam int OW = $clog2(NUM_MACROS);
  localparam int CW = $clog2(MAX_TENURE) + 1;
  localparam int TW = $clog2(TURNAROUND) + 1;
  localparam logic [CW-1:0] TEN_LAST  = CW'(MAX_TENURE - 1);
  localparam logic [TW-1:0] TURN_LOAD = TW'(TURNAROUND - 1);

  state_t                  state_q, state_d;
  logic [OW-1:0]           owner_q, owner_d;
  logic [OW-1:0]           ptr_q, ptr_d;
  logic [CW-1:0]           ten_q, ten_d;
  logic [TW-1:0]           turn_q, turn_d;
  logic [NUM_MACROS-1:0]   gnt_q, gnt_d;
  logic                    exp_q, exp_d;

  logic [2*NUM_MACROS-1:0] req_dbl;
  logic [OW-1:0]           pick;
  logic                    pick_vld;
  logic                    own_req, own_rel;
  logic                    ten_hit;

  assign mac_i   = pad_i;
  assign gnt     = gnt_q;
  assign owner   = owner_q;
  assign busy    = (state_q == ST_GRANT);
  assign expired = exp_q;
  assign req_dbl = {req, req};
  assign ten_hit = (ten_q == TEN_LAST);

  // Descending scan so the requester closest above ptr wins.
  always_comb begin
    int p;
    p        = 0;
    pick     = '0;
    pick_vld = 1'b0;
    for (int i = NUM_MACROS - 1; i >= 0; i--) begin
      if (req_dbl[int'(ptr_q) + i]) begin
        p = int'(ptr_q) + i;
        if (p >= NUM_MACROS) p = p - NUM_MACROS;
        pick     = OW'(p);
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    own_req = 1'b0;
    own_rel = 1'b0;
    for (int k = 0; k < NUM_MACROS; k++) begin
      if (owner_q == OW'(k)) begin
        own_req = req[k];
        own_rel = rel[k];
      end
    end
  end

  always_comb begin
    pad_o  = '0;
    pad_oe = '0;
    if (state_q == ST_GRANT) begin
      for (int k = 0; k < NUM_MACROS; k++) begin
        if (owner_q == OW'(k)) begin
          pad_o  = mac_o[k*WIDTH +: WIDTH];
          pad_oe = mac_oe[k*WIDTH +: WIDTH];
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    ten_d   = ten_q;
    turn_d  = turn_q;
    gnt_d   = gnt_q;
    exp_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        gnt_d = '0;
        if (pick_vld) begin
          owner_d = pick;
          gnt_d   = NUM_MACROS'(1) << pick;
          ten_d   = '0;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        ten_d = ten_q + CW'(1);
        if (own_rel || !own_req || ten_hit) begin
          gnt_d   = '0;
          ptr_d   = (owner_q == OW'(NUM_MACROS - 1)) ? '0 : owner_q + OW'(1);
          turn_d  = TURN_LOAD;
          state_d = ST_TURN;
          // Only a pure timeout counts as forced termination.
          exp_d   = ten_hit && own_req && !own_rel;
        end
      end
      ST_TURN: begin
        gnt_d = '0;
        if (turn_q == '0) state_d = ST_IDLE;
        else              turn_d  = turn_q - TW'(1);
      end
      default: begin
        gnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      ten_q   <= '0;
      turn_q  <= '0;
      gnt_q   <= '0;
      exp_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      ten_q   <= ten_d;
      turn_q  <= turn_d;
      gnt_q   <= gnt_d;
      exp_q   <= exp_d;
    end
  end

endmodule

// File: tb/tb_macro_io_arbiter.sv
// Bench for macro_io_arbiter: timestamp-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_macro_io_arbiter;
  localparam int N  = 4;
  localparam int W  = 10;
  localparam int MT = 16;
  localparam int TA = 1;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req, rel;
  logic [N*W-1:0] mac_o, mac_oe;
  logic [W-1:0]   pad_i, mac_i, pad_o, pad_oe;
  logic [N-1:0]   gnt;
  logic [1:0]     owner;
  logic           busy, expired;

  int n_pass = 0;
  int n_total = 0;
  bit run_chk = 1'b0;

  macro_io_arbiter #(.NUM_MACROS(N), .WIDTH(W), .MAX_TENURE(MT), .TURNAROUND(TA)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .rel(rel), .mac_o(mac_o), .mac_oe(mac_oe),
    .pad_i(pad_i), .mac_i(mac_i), .pad_o(pad_o), .pad_oe(pad_oe), .gnt(gnt),
    .owner(owner), .busy(busy), .expired(expired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Model: a grant started at edge m_start has been held (edge - m_start) cycles;
  // after a release at edge E the bus may next be arbitrated at edge E+TA+1.
  int cyc = 0;
  bit m_hold, m_exp;
  int m_owner, m_ptr, m_start, m_next_arb;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_hold = 0; m_exp = 0; m_owner = 0; m_ptr = 0; m_start = 0;
      m_next_arb = cyc + 1;
    end else begin
      cyc++;
      m_exp = 0;
      if (m_hold) begin
        int held;
        held = cyc - m_start;
        if (rel[m_owner] || !req[m_owner] || held >= MT) begin
          m_exp      = (held >= MT) && req[m_owner] && !rel[m_owner];
          m_hold     = 0;
          m_ptr      = (m_owner + 1) % N;
          m_next_arb = cyc + TA + 1;
        end
      end else if (cyc >= m_next_arb && req != '0) begin
        bit found;
        found = 0;
        for (int k = 0; k < N; k++) begin
          if (!found && req[(m_ptr + k) % N]) begin
            m_owner = (m_ptr + k) % N;
            found   = 1;
          end
        end
        m_hold  = 1;
        m_start = cyc;
      end
    end
  end

  always @(negedge clk) begin
    if (run_chk) begin
      chk("gnt",     gnt,     m_hold ? (64'd1 << m_owner) : 64'd0);
      chk("owner",   owner,   m_owner);
      chk("busy",    busy,    m_hold);
      chk("expired", expired, m_exp);
      chk("pad_o",   pad_o,   m_hold ? mac_o[m_owner*W +: W]  : '0);
      chk("pad_oe",  pad_oe,  m_hold ? mac_oe[m_owner*W +: W] : '0);
      chk("mac_i",   mac_i,   pad_i);
    end
  end

  always @(posedge clk) pad_i <= W'($urandom);

  initial begin
    int run1, n_exp, rises;
    int order[5];
    logic prev0, prevb;

    rst_n = 1'b0; req = '0; rel = '0; pad_i = '0;
    for (int k = 0; k < N; k++) begin
      mac_o[k*W +: W]  = W'(10'h155 + 10'h2B * k);
      mac_oe[k*W +: W] = W'(10'h3F0 >> k);
    end
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    run_chk = 1'b1;
    @(negedge clk);
    chk("reset_gnt", gnt, 0);
    chk("reset_owner", owner, 0);
    chk("reset_pad_oe", pad_oe, 0);

    // Lowest requester above ptr=0 is macro 1
    #1 req = 4'b0110;
    @(negedge clk);
    chk("first_gnt", gnt, 4'b0010);
    chk("first_owner", owner, 1);
    chk("first_pad_o", pad_o, 10'h155 + 10'h2B);
    @(negedge clk);
    @(negedge clk);
    #1 rel = 4'b0010;
    @(negedge clk);
    chk("rel_gnt", gnt, 0);
    chk("rel_pad_oe", pad_oe, 0);
    #1 rel = '0;
    @(negedge clk);
    chk("idle_gnt", gnt, 0);
    @(negedge clk);
    chk("regrant_gnt", gnt, 4'b0100);
    chk("regrant_owner", owner, 2);
    #1 req = '0;
    repeat (4) @(negedge clk);

    // Lone requester: full tenure, one expiry, re-grant
    #1 req = 4'b0001;
    run1 = 0; n_exp = 0; rises = 0; prev0 = 1'b0;
    for (int i = 0; i < 60 && rises < 2; i++) begin
      @(negedge clk);
      if (gnt[0] && !prev0) rises++;
      if (gnt[0] && rises == 1) run1++;
      if (expired) n_exp++;
      prev0 = gnt[0];
    end
    chk("lone_len", run1, MT);
    chk("lone_expired", n_exp, 1);
    chk("lone_regrant", rises, 2);

    // All request: round-robin 0,1,2,3,0 via expiry
    #1 rst_n = 1'b0; req = 4'b1111;
    @(negedge clk);
    #1 rst_n = 1'b1;
    rises = 0; n_exp = 0; prevb = 1'b0;
    for (int i = 0; i < 120 && rises < 5; i++) begin
      @(negedge clk);
      if (expired) n_exp++;
      if (busy && !prevb) begin
        order[rises] = owner;
        rises++;
      end
      prevb = busy;
    end
    chk("rr_count", rises, 5);
    chk("rr_order0", order[0], 0);
    chk("rr_order1", order[1], 1);
    chk("rr_order2", order[2], 2);
    chk("rr_order3", order[3], 3);
    chk("rr_order4", order[4], 0);
    chk("rr_expired", n_exp, 4);

    // Asynchronous reset in the middle of a grant
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async_gnt", gnt, 0);
    chk("async_pad_oe", pad_oe, 0);
    chk("async_busy", busy, 0);
    req = 4'b1000;
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_gnt", gnt, 4'b1000);

    // Non-owner noise; owner drops req on the same edge the tenure limit hits
    for (int c = 1; c <= MT; c++) begin
      #1;
      req = (c == MT) ? 4'b0101 : ((c % 2) ? 4'b1010 : 4'b1111);
      rel = (c % 2) ? 4'b0111 : 4'b0000;
      @(negedge clk);
    end
    chk("coinc_gnt", gnt, 0);
    chk("coinc_expired", expired, 0);
    #1 rel = '0;
    @(negedge clk);
    chk("coinc_turn_gnt", gnt, 0);
    chk("coinc_turn_expired", expired, 0);
    @(negedge clk);
    chk("coinc_next_gnt", gnt, 4'b0001);
    #1 req = '0;
    repeat (5) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
